// File: rtl/uart_status_line_parser.sv
// uart_status_line_parser: decodes "<Red|Green|Blue> <ON|OFF>\r\n" lines and mirrors remote LED state
module uart_status_line_parser #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     received,
  input  logic [7:0]               rx_byte,
  input  logic                     recv_error,
  output logic                     led_red_state,
  output logic                     led_green_state,
  output logic                     led_blue_state,
  output logic                     msg_valid,
  output logic [1:0]               msg_color,
  output logic                     msg_on,
  output logic                     parse_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  typedef enum logic [3:0] {S_HEAD, S_NAME, S_SPACE, S_O, S_NF, S_F2, S_CR, S_LF, S_DISCARD} state_t;
  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] LF = 8'h0a;
  state_t      state;
  logic [1:0]  color;
  logic [2:0]  idx;
  logic        on;
  logic [39:0] name_str;
  logic [2:0]  name_len;
  logic [7:0]  name_ch;
  logic        hit;
  logic        fail;
  always_comb begin
    name_str = color == 2'd0 ? 40'("Red") : color == 2'd1 ? 40'("Green") : 40'("Blue");
    name_len = color == 2'd0 ? 3'd3 : color == 2'd1 ? 3'd5 : 3'd4;
    name_ch  = 8'(name_str >> (8 * (name_len - 3'd1 - idx)));
    hit = state == S_NAME  ? rx_byte == name_ch :
          state == S_SPACE ? rx_byte == " " :
          state == S_O     ? rx_byte == "O" :
          state == S_NF    ? (rx_byte == "N" || rx_byte == "F") :
          state == S_F2    ? rx_byte == "F" :
          state == S_CR    ? rx_byte == CR :
          state == S_LF    ? rx_byte == LF : 1'b0;
    fail = received && !recv_error && rx_byte == LF && state != S_HEAD && !hit;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_HEAD;
      color           <= 2'd0;
      idx             <= 3'd0;
      on              <= 1'b0;
      led_red_state   <= 1'b0;
      led_green_state <= 1'b0;
      led_blue_state  <= 1'b0;
      msg_valid       <= 1'b0;
      msg_color       <= 2'd0;
      msg_on          <= 1'b0;
      parse_error     <= 1'b0;
      err_count       <= '0;
    end else begin
      msg_valid   <= 1'b0;
      parse_error <= fail;
      if (fail && ~&err_count) err_count <= err_count + 1'b1;
      // a framing error poisons any partial line; idle and discard states are unaffected
      if (recv_error) begin
        if (state != S_HEAD) state <= S_DISCARD;
      end else if (received) begin
        if (state == S_HEAD) begin
          if (rx_byte == "R" || rx_byte == "G" || rx_byte == "B") begin
            color <= rx_byte == "R" ? 2'd0 : rx_byte == "G" ? 2'd1 : 2'd2;
            idx   <= 3'd1;
            state <= S_NAME;
          end else if (rx_byte != CR && rx_byte != LF) state <= S_DISCARD;
        end else if (hit) begin
          case (state)
            S_NAME: begin
              idx   <= idx + 3'd1;
              state <= idx == name_len - 3'd1 ? S_SPACE : S_NAME;
            end
            S_SPACE: state <= S_O;
            S_O:     state <= S_NF;
            S_NF: begin
              on    <= rx_byte == "N";
              state <= rx_byte == "N" ? S_CR : S_F2;
            end
            S_F2:    state <= S_CR;
            S_CR:    state <= S_LF;
            S_LF: begin
              msg_valid <= 1'b1;
              msg_color <= color;
              msg_on    <= on;
              if (color == 2'd0) led_red_state <= on;
              if (color == 2'd1) led_green_state <= on;
              if (color == 2'd2) led_blue_state <= on;
              state <= S_HEAD;
            end
            default: state <= S_HEAD;
          endcase
        end else state <= rx_byte == LF ? S_HEAD : S_DISCARD;
      end
    end
  end
endmodule

// File: tb/tb_uart_status_line_parser.sv
// tb_uart_status_line_parser: random line traffic checked against a whole-line reference model
module tb_uart_status_line_parser;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       recv_error = 1'b0;
  logic       led_red_state, led_green_state, led_blue_state;
  logic       msg_valid, msg_on, parse_error;
  logic [1:0] msg_color;
  logic [7:0] err_count;
  int n_tests = 0;
  int n_fail = 0;
  logic [127:0] lines [6];
  int           line_len [6];
  logic         m_red, m_green, m_blue, m_valid, m_on, m_perr;
  logic [1:0]   m_color;
  logic [7:0]   m_cnt;
  logic [127:0] mbuf;
  int           mlen;
  logic         mpois;
  uart_status_line_parser #(.ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte), .recv_error(recv_error),
    .led_red_state(led_red_state), .led_green_state(led_green_state), .led_blue_state(led_blue_state),
    .msg_valid(msg_valid), .msg_color(msg_color), .msg_on(msg_on),
    .parse_error(parse_error), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // a line is judged only when its newline arrives: exact match of everything since the last boundary
  task automatic model();
    int hit;
    if (!rst_n) begin
      {m_red, m_green, m_blue, m_valid, m_on, m_perr, m_color, m_cnt} = '0;
      mbuf = '0; mlen = 0; mpois = 1'b0;
    end else begin
      m_valid = 1'b0; m_perr = 1'b0;
      if (recv_error) begin
        if (mlen != 0) mpois = 1'b1;
      end else if (received) begin
        if (rx_byte == 8'h0a) begin
          if (mlen != 0) begin
            hit = -1;
            for (int k = 0; k < 6; k++) if (!mpois && mlen == line_len[k] && mbuf == lines[k]) hit = k;
            if (hit >= 0) begin
              m_valid = 1'b1; m_color = 2'(hit / 2); m_on = (hit % 2) == 0;
              if (m_color == 2'd0) m_red = m_on;
              if (m_color == 2'd1) m_green = m_on;
              if (m_color == 2'd2) m_blue = m_on;
            end else begin
              m_perr = 1'b1;
              if (m_cnt != 8'hff) m_cnt++;
            end
          end
          mbuf = '0; mlen = 0; mpois = 1'b0;
        end else if (!(mlen == 0 && rx_byte == 8'h0d)) begin
          mbuf = {mbuf[119:0], rx_byte};
          if (mlen < 17) mlen++;
        end
      end
    end
  endtask
  task automatic step(input logic rv, input logic [7:0] b, input logic re, input logic rs);
    @(negedge clk);
    received = rv; rx_byte = b; recv_error = re; rst_n = rs;
    @(posedge clk);
    model();
    #1;
    check("msg_valid", 32'(msg_valid), 32'(m_valid));
    check("parse_error", 32'(parse_error), 32'(m_perr));
    check("led_red", 32'(led_red_state), 32'(m_red));
    check("led_green", 32'(led_green_state), 32'(m_green));
    check("led_blue", 32'(led_blue_state), 32'(m_blue));
    check("msg_color", 32'(msg_color), 32'(m_color));
    check("msg_on", 32'(msg_on), 32'(m_on));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask
  // '~' stands for CR and '|' for LF
  task automatic send_str(input string s, input int gap);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      b = b == "~" ? 8'h0d : b == "|" ? 8'h0a : b;
      step(1'b1, b, 1'b0, 1'b1);
      repeat (gap) step(1'b0, 8'($urandom), 1'b0, 1'b1);
    end
  endtask
  initial begin
    logic [7:0] q [$];
    int kind, k, pos;
    lines[0] = "Red ON\015";    line_len[0] = 7;
    lines[1] = "Red OFF\015";   line_len[1] = 8;
    lines[2] = "Green ON\015";  line_len[2] = 9;
    lines[3] = "Green OFF\015"; line_len[3] = 10;
    lines[4] = "Blue ON\015";   line_len[4] = 8;
    lines[5] = "Blue OFF\015";  line_len[5] = 9;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    send_str("Red ON~|", 3);
    send_str("Green ON~|Blue ON~|Green OFF~|", 0);
    send_str("Red OX~|Blue OFF~|", 1);
    send_str("Gre|Red OFF~|", 0);
    send_str("Blue O", 0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    send_str("N~|", 0);
    send_str("Blue O", 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    send_str("N~|", 0);
    send_str("~|Red ON~~|", 0);
    repeat (400) begin
      kind = $urandom_range(0, 9);
      k = $urandom_range(0, 5);
      q.delete();
      for (int i = line_len[k] - 1; i >= 0; i--) q.push_back(lines[k][8*i +: 8]);
      q.push_back(8'h0a);
      pos = $urandom_range(0, q.size() - 2);
      if (kind == 5) q[pos] = q[pos] ^ 8'($urandom_range(1, 255));
      if (kind == 6) q = '{8'h0d, 8'h0a};
      if (kind == 7) begin q = q[0:pos]; q.push_back(8'h0a); end
      for (int i = 0; i < q.size(); i++) begin
        if (kind == 8 && i == pos) step($urandom_range(0, 1) == 1, q[i], 1'b1, 1'b1);
        if (kind == 9 && i == pos) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, q[i], 1'b0, 1'b1);
        repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'b0, 1'b1);
      end
    end
    repeat (300) send_str("X|~|", 0);
    check("err_sat", 32'(err_count), 32'd255);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
